// File: rtl/game_timer_if.sv
// Control/status bundle for game_timer: the controller drives Start/Pause/Load,
// the timer returns the BCD count, pulses, levels and its current FSM state.
interface game_timer_if #(
  parameter int DIGITS = 2
);
  logic                  Start;
  logic                  Pause;
  logic                  Load;
  logic [4*DIGITS-1:0]   LoadValue;
  logic [4*DIGITS-1:0]   BcdValue;
  logic                  Tick;
  logic                  Running;
  logic                  Expired;
  logic                  Done;
  logic                  Warning;
  logic [1:0]            StateDbg;

  modport master (
    output Start, Pause, Load, LoadValue,
    input  BcdValue, Tick, Running, Expired, Done, Warning, StateDbg
  );

  modport slave (
    input  Start, Pause, Load, LoadValue,
    output BcdValue, Tick, Running, Expired, Done, Warning, StateDbg
  );
endinterface

// File: rtl/game_timer.sv
// BCD countdown game timer with one-second prescaler and IDLE/RUN/PAUSED/DONE FSM.
// Optional low-time Warning output is built only when GAME_TIMER_WARN_EN is defined.
module game_timer #(
  parameter int                     CLOCK_FREQUENCY = 50000000,
  parameter int                     DIGITS          = 2,
  parameter logic [4*DIGITS-1:0]    START_VALUE     = 'h60
) (
  input  logic        ClockIn,
  input  logic        Reset,
  game_timer_if.slave Bus
);

  localparam int PW = $clog2(CLOCK_FREQUENCY);
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(CLOCK_FREQUENCY - 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, nextState;
  logic [BW-1:0]   bcdReg, nextBcd;
  logic [PW-1:0]   prescReg, nextPresc;
  logic            tickReg, nextTick;
  logic            expiredReg, nextExpired;
  logic            runningReg;
  logic            doneReg;
  logic [BW-1:0]   decValue;
  logic [BW-1:0]   loadClamped;
  logic            startReq;

  // Borrow ripples upward only through zero digits.
  function automatic logic [BW-1:0] bcdDec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] bcdClamp(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  assign decValue    = bcdDec(bcdReg);
  assign loadClamped = bcdClamp(Bus.LoadValue);
  // Pause overrides Start, and a zero count can never be started.
  assign startReq    = Bus.Start && !Bus.Pause && (bcdReg != '0);

  always_comb begin
    nextState   = state;
    nextBcd     = bcdReg;
    nextPresc   = prescReg;
    nextTick    = 1'b0;
    nextExpired = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Bus.Load) begin
          nextBcd   = loadClamped;
          nextState = IDLE;
        end else if (startReq) begin
          nextState = RUN;
          nextPresc = PRESC_RELOAD;
        end
      end
      RUN: begin
        if (Bus.Pause) begin
          nextState = PAUSED;
        end else if (prescReg == '0) begin
          nextPresc = PRESC_RELOAD;
          nextBcd   = decValue;
          nextTick  = 1'b1;
          if (decValue == '0) begin
            nextState   = DONE;
            nextExpired = 1'b1;
          end
        end else begin
          nextPresc = prescReg - 1'b1;
        end
      end
      PAUSED: begin
        // Resuming keeps the held prescaler so the partial second is honoured.
        if (Bus.Load) begin
          nextBcd = loadClamped;
        end else if (startReq) begin
          nextState = RUN;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state      <= IDLE;
      bcdReg     <= START_VALUE;
      prescReg   <= PRESC_RELOAD;
      tickReg    <= 1'b0;
      expiredReg <= 1'b0;
      runningReg <= 1'b0;
      doneReg    <= 1'b0;
    end else begin
      state      <= nextState;
      bcdReg     <= nextBcd;
      prescReg   <= nextPresc;
      tickReg    <= nextTick;
      expiredReg <= nextExpired;
      runningReg <= (nextState == RUN);
      doneReg    <= (nextState == DONE);
    end
  end

`ifdef GAME_TIMER_WARN_EN
  logic        warningReg;
  logic [31:0] nextWide;

  assign nextWide = 32'(nextBcd);

  // BCD ordering matches binary ordering, so a plain compare against 'h10 works.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      warningReg <= 1'b0;
    end else begin
      warningReg <= ((nextState == RUN) || (nextState == PAUSED)) &&
                    (nextWide != 32'h0) && (nextWide <= 32'h10);
    end
  end

  assign Bus.Warning = warningReg;
`else
  assign Bus.Warning = 1'b0;
`endif

  assign Bus.BcdValue = bcdReg;
  assign Bus.Tick     = tickReg;
  assign Bus.Expired  = expiredReg;
  assign Bus.Running  = runningReg;
  assign Bus.Done     = doneReg;
  assign Bus.StateDbg = state;

endmodule

// File: tb/tb_game_timer.sv
// Randomized plus directed bench for game_timer (4-cycle seconds, 2 BCD digits),
// checked against a seconds/elapsed-cycles reference model.
module tb_game_timer;

  localparam int CF = 4;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  logic ClockIn;
  logic Reset;

  game_timer_if #(.DIGITS(2)) bus ();

  game_timer #(
    .CLOCK_FREQUENCY(CF),
    .DIGITS(2),
    .START_VALUE(8'h60)
  ) dut (
    .ClockIn(ClockIn),
    .Reset(Reset),
    .Bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: remaining whole seconds and cycles already spent in this second.
  int mode    = M_IDLE;
  int secs    = 60;
  int elapsed = 0;
  bit expTick = 1'b0;
  bit expExp  = 1'b0;

  initial begin
    ClockIn = 1'b0;
    forever #5 ClockIn = ~ClockIn;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampSecs(input logic [7:0] lv);
    int tens, ones;
    tens = (lv[7:4] > 9) ? 9 : int'(lv[7:4]);
    ones = (lv[3:0] > 9) ? 9 : int'(lv[3:0]);
    return tens * 10 + ones;
  endfunction

  function automatic logic [7:0] toBcd(input int s);
    return {4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic model_step(input bit s, input bit p, input bit l, input logic [7:0] lv, input bit r);
    expTick = 1'b0;
    expExp  = 1'b0;
    if (r) begin
      mode = M_IDLE; secs = 60; elapsed = 0;
    end else begin
      case (mode)
        M_IDLE, M_DONE: begin
          if (l) begin
            secs = clampSecs(lv); mode = M_IDLE;
          end else if (s && !p && secs != 0) begin
            mode = M_RUN; elapsed = 0;
          end
        end
        M_RUN: begin
          if (p) begin
            mode = M_PAUSED;
          end else begin
            elapsed++;
            if (elapsed == CF) begin
              elapsed = 0;
              secs--;
              expTick = 1'b1;
              if (secs == 0) begin
                mode = M_DONE; expExp = 1'b1;
              end
            end
          end
        end
        default: begin
          if (l) secs = clampSecs(lv);
          else if (s && !p && secs != 0) mode = M_RUN;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    bit expWarn;
`ifdef GAME_TIMER_WARN_EN
    expWarn = (mode == M_RUN || mode == M_PAUSED) && secs >= 1 && secs <= 10;
`else
    expWarn = 1'b0;
`endif
    check("bcd",     32'(bus.BcdValue), 32'(toBcd(secs)));
    check("tick",    32'(bus.Tick),     32'(expTick));
    check("expired", 32'(bus.Expired),  32'(expExp));
    check("running", 32'(bus.Running),  32'(mode == M_RUN));
    check("done",    32'(bus.Done),     32'(mode == M_DONE));
    check("warning", 32'(bus.Warning),  32'(expWarn));
  endtask

  // Drive one cycle of inputs, step the model on the edge, compare mid-cycle.
  task automatic cyc(input bit s, input bit p, input bit l, input logic [7:0] lv, input bit r);
    bus.Start = s; bus.Pause = p; bus.Load = l; bus.LoadValue = lv; Reset = r;
    @(posedge ClockIn);
    model_step(s, p, l, lv, r);
    @(negedge ClockIn);
    compare_all();
    bus.Start = 1'b0; bus.Pause = 1'b0; bus.Load = 1'b0; Reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0);
  endtask

  initial begin
    bus.Start = 1'b0; bus.Pause = 1'b0; bus.Load = 1'b0; bus.LoadValue = 8'h00;
    Reset = 1'b1;
    @(negedge ClockIn);

    cyc(0, 0, 0, 8'h00, 1);
    check("rst_bcd", 32'(bus.BcdValue), 32'h60);
    check("rst_running", 32'(bus.Running), 32'h0);

    // Plain countdown from the reset value.
    cyc(1, 0, 0, 8'h00, 0);
    check("start_running", 32'(bus.Running), 32'h1);
    idle(3);
    cyc(0, 0, 0, 8'h00, 0);
    check("first_dec", 32'(bus.BcdValue), 32'h59);
    check("first_tick", 32'(bus.Tick), 32'h1);
    idle(3);
    cyc(0, 0, 0, 8'h00, 0);
    check("second_dec", 32'(bus.BcdValue), 32'h58);

    // Borrow across digits, then digit clamping on load.
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h10, 0);
    cyc(1, 0, 0, 8'h00, 0);
    idle(3);
    cyc(0, 0, 0, 8'h00, 0);
    check("borrow", 32'(bus.BcdValue), 32'h09);
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h3F, 0);
    check("clamp", 32'(bus.BcdValue), 32'h39);

    // Pause two cycles into a second; resume finishes the remaining two.
    cyc(1, 0, 0, 8'h00, 0);
    idle(2);
    cyc(0, 1, 0, 8'h00, 0);
    idle(10);
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 0);
    check("resume_hold", 32'(bus.BcdValue), 32'h39);
    cyc(0, 0, 0, 8'h00, 0);
    check("resume_dec", 32'(bus.BcdValue), 32'h38);

    // Expiry from 01.
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h01, 0);
    cyc(1, 0, 0, 8'h00, 0);
    idle(3);
    cyc(0, 0, 0, 8'h00, 0);
    check("exp_bcd", 32'(bus.BcdValue), 32'h00);
    check("exp_pulse", 32'(bus.Expired), 32'h1);
    check("exp_done", 32'(bus.Done), 32'h1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 8'h00, 0);
      check("done_no_tick", 32'(bus.Tick), 32'h0);
    end

    // Start+Pause in IDLE, Load ignored in RUN.
    cyc(0, 0, 1, 8'h25, 0);
    cyc(1, 1, 0, 8'h00, 0);
    check("sp_idle", 32'(bus.Running), 32'h0);
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h20, 0);
    idle(2);
    cyc(0, 0, 0, 8'h00, 0);
    check("run_load_ignored", 32'(bus.BcdValue), 32'h24);

    // Reset mid-run.
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h42, 0);
    cyc(1, 0, 0, 8'h00, 0);
    idle(2);
    cyc(1, 0, 0, 8'h00, 1);
    check("midrun_rst_bcd", 32'(bus.BcdValue), 32'h60);
    check("midrun_rst_run", 32'(bus.Running), 32'h0);

    // Short run through the low-time window to DONE.
    cyc(0, 0, 1, 8'h12, 0);
    cyc(1, 0, 0, 8'h00, 0);
    idle(60);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0,
          8'($urandom_range(255)), $urandom_range(199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
